// File: rtl/hc595_driver.sv
// Serial driver for a chain of 74HC595 shift registers: shifts one DATA_W-bit
// frame out MSB first on ser/srclk, then pulses rclk to latch it.
module hc595_driver #(
    parameter int DATA_W = 16,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ser,
    output logic              srclk,
    output logic              rclk,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = $clog2(DIV + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ser_q, ser_d;
    logic              srclk_q, srclk_d;
    logic              rclk_q, rclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_end;

    assign phase_end = (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                if (start) begin
                    shift_d   = data;
                    bit_cnt_d = CNT_W'(DATA_W);
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    state_d   = S_HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    state_d   = (bit_cnt_q == CNT_W'(1)) ? S_LATCH : S_SETUP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it;
        // ser only moves when a SETUP (srclk low) phase begins.
        srclk_d = (state_d == S_HIGH);
        rclk_d  = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
        ser_d   = (state_d == S_SETUP) ? shift_d[DATA_W-1] : ser_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ser_q     <= 1'b0;
            srclk_q   <= 1'b0;
            rclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ser_q     <= ser_d;
            srclk_q   <= srclk_d;
            rclk_q    <= rclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ser   = ser_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Scoreboard bench for hc595_driver: default instance plus a DIV=1 instance.
module tb_hc595_driver;

    localparam int DATA_W = 16;
    localparam int DIV    = 4;
    localparam int FRAME  = 2 * DIV * DATA_W + DIV + 1;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] data   = 16'h0;
    logic [15:0] data1  = 16'h0;
    logic        ser, srclk, rclk, busy, done;
    logic        ser1, srclk1, rclk1, busy1, done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    hc595_driver #(.DATA_W(DATA_W), .DIV(DIV)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .ser(ser), .srclk(srclk), .rclk(rclk), .busy(busy), .done(done)
    );

    hc595_driver #(.DATA_W(DATA_W), .DIV(1)) u_dut_div1 (
        .clk(clk), .rst(rst), .start(start1), .data(data1),
        .ser(ser1), .srclk(srclk1), .rclk(rclk1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        data  = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Scoreboard state for the default instance
    logic [15:0] frame_q[$];
    logic [15:0] cap = '0;
    logic [15:0] exp_frame;
    int acc_c = 0, done_c = 0, next_free = 0;
    int nbits = 0, rclk_w = 0;
    logic prev_srclk = 1'b0, prev_rclk = 1'b0, prev_ser = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_outputs", 32'({ser, srclk, rclk, busy, done}), 32'd0);
            frame_q.delete();
            acc_c = 0; done_c = 0; next_free = 0;
            nbits = 0; rclk_w = 0;
            prev_srclk = 1'b0; prev_rclk = 1'b0; prev_ser = 1'b0;
        end else begin
            check_eq("no_overlap", 32'(srclk & rclk), 32'd0);
            if (prev_srclk && srclk) check_eq("ser_stable", 32'(ser), 32'(prev_ser));
            check_eq("busy", 32'(busy), 32'(cyc > acc_c && cyc < done_c));
            check_eq("done", 32'(done), 32'(done_c != 0 && cyc == done_c));
            if (done) check_eq("done_when_idle", 32'(busy), 32'd0);
            if (srclk && !prev_srclk) begin
                cap = {cap[14:0], ser};
                nbits++;
            end
            if (rclk) rclk_w++;
            if (prev_rclk && !rclk) begin
                check_eq("rclk_width", 32'(rclk_w), 32'(DIV));
                check_eq("bit_count", 32'(nbits), 32'(DATA_W));
                check_eq("frame_pending", 32'(frame_q.size() != 0), 32'd1);
                if (frame_q.size() != 0) begin
                    exp_frame = frame_q.pop_front();
                    check_eq("frame", 32'(cap), 32'(exp_frame));
                    $display("frame latched %04h expected %04h", cap, exp_frame);
                end
                nbits = 0;
                rclk_w = 0;
            end
            // Model acceptance: the next edge takes start only once the previous frame has finished
            if (start && cyc >= next_free) begin
                frame_q.push_back(data);
                acc_c = cyc;
                done_c = cyc + FRAME;
                next_free = done_c;
            end
            prev_srclk = srclk;
            prev_rclk  = rclk;
            prev_ser   = ser;
        end
    end

    int bits1, last1, ndone1;
    logic [15:0] cap1;
    logic p1;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        send(16'hFEC0);
        repeat (140) step();

        // Re-pulsed start with new data mid-frame must be ignored
        send(16'hA55A);
        repeat (8) step();
        send(16'h1111);
        repeat (39) step();
        send(16'h2222);
        repeat (100) step();

        // start held high: three back-to-back frames
        data  = 16'h1234;
        start = 1'b1;
        repeat (150) step();
        data = 16'h5678;
        repeat (150) step();
        start = 1'b0;
        repeat (140) step();

        // Asynchronous reset mid-frame, then a clean frame
        send(16'h0F0F);
        repeat (68) step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_eq("async_rst", 32'({ser, srclk, rclk, busy, done}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        send(16'hC3A5);
        repeat (140) step();
        check_eq("queue_empty", 32'(frame_q.size()), 32'd0);

        // DIV=1 instance
        data1  = 16'h0001;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        bits1 = 0; last1 = 0; ndone1 = 0; cap1 = '0; p1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            check_eq("div1_overlap", 32'(srclk1 & rclk1), 32'd0);
            if (srclk1 && !p1) begin
                bits1++;
                if (bits1 > 1) check_eq("div1_period", 32'(k - last1), 32'd2);
                last1 = k;
                cap1 = {cap1[14:0], ser1};
                check_eq("div1_ser", 32'(ser1), 32'(bits1 == 16));
            end
            if (done1) begin
                ndone1++;
                check_eq("div1_done_cycle", 32'(k), 32'd34);
            end
            p1 = srclk1;
            step();
        end
        check_eq("div1_done_count", 32'(ndone1), 32'd1);
        check_eq("div1_bits", 32'(bits1), 32'd16);
        check_eq("div1_frame", 32'(cap1), 32'h0001);
        $display("div1 frame %04h bits %0d done pulses %0d", cap1, bits1, ndone1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hc595_driver.md
HC595_DRIVER -- requirements
Module: hc595_driver

Interface
REQ-001 Parameter DATA_W, default 16: bits per frame; data[15:8] is the digit-select byte and data[7:0] is the common-anode segment byte (DP G F E D C B A).
REQ-002 Parameter DIV, default 4: clk cycles per srclk half-period; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  frame request; sampled only while busy=0.
REQ-006 data  input  DATA_W  frame payload, captured in the cycle start is accepted.
REQ-007 ser  output  1  serial data to 74HC595 SER, MSB first.
REQ-008 srclk  output  1  shift clock to 74HC595 SRCLK.
REQ-009 rclk  output  1  storage-latch clock to 74HC595 RCLK.
REQ-010 busy  output  1  high from the cycle after acceptance until frame completion.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-013 FSM states SHALL be IDLE, SETUP, HIGH and LATCH.
REQ-014 IDLE transitions:
- start=1 at an edge: load data into the shift register, set bit count to DATA_W, go to SETUP.
- start=0: remain in IDLE.
REQ-015 SETUP behaviour:
- srclk=0; ser = shift-register MSB.
- Hold DIV cycles, then go to HIGH.
REQ-016 HIGH behaviour:
- srclk=1; ser unchanged.
- Hold DIV cycles.
- On exit: shift the register left by one, decrement the count.
- Go to LATCH if the count reaches 0, else SETUP.
REQ-017 LATCH behaviour:
- srclk=0, rclk=1 for DIV cycles.
- Then go to IDLE, with done=1 and busy=0 for exactly that first IDLE cycle.
REQ-018 ser SHALL change only while srclk=0, and SHALL be stable for the full srclk high phase.
REQ-019 rclk SHALL be high only in LATCH; srclk and rclk SHALL never be high together.
REQ-020 With start accepted at edge 0, busy SHALL be 1 for cycles 1..(2*DIV*DATA_W + DIV), and done SHALL be 1 in cycle 1 + 2*DIV*DATA_W + DIV (133 with defaults).
REQ-021 start while busy=1 SHALL be ignored, with no queuing; data changes while busy=1 SHALL not affect the frame in flight.
REQ-022 start held high continuously SHALL launch a new frame on the edge where done=1, giving back-to-back frames with one IDLE cycle between them.
REQ-023 Bit order: data[DATA_W-1] is shifted first, so data[15:8] ends in the far (cascaded) 595 and data[7:0] in the near 595.
REQ-024 The internal DIV counter SHALL be $clog2(DIV+1) bits wide and the bit counter $clog2(DATA_W+1) bits wide, with no wrap inside a phase.

Reset
REQ-025 While rst=1, regardless of clk: state=IDLE, ser=0, srclk=0, rclk=0, busy=0, done=0, shift register=0, counters=0.
REQ-026 Reset mid-frame SHALL abandon the frame without pulsing rclk, so the 595 outputs keep their previously latched value.
REQ-027 The first start after rst deasserts SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-028 Defaults, data=16'hFEC0, one-cycle start: the bench SHALL capture 16 bits on srclk rising edges equal to 1111_1110_1100_0000 in order, see exactly one rclk pulse 4 cycles wide, and see done in cycle 133.
REQ-029 DIV=1, data=16'h0001: srclk period = 2 clk cycles; ser=1 only during the 16th bit; done in cycle 1+32+1=34.
REQ-030 start re-pulsed at cycles 10 and 50 with different data during a frame: no effect; the captured frame equals the original data and only one done pulse occurs.
REQ-031 start held high for 3 frames: done pulses at cycles 133, 266 and 399, with busy low only in those cycles.
REQ-032 rst asserted asynchronously at cycle 70 mid-frame: all outputs are 0 within the same cycle, no rclk pulse occurs, and a following start produces a full, correct frame.
REQ-033 Scoreboard invariants checked every cycle for all tests:
- srclk and rclk are never both high.
- ser does not change while srclk=1.
- done is asserted only when busy=0.
